alu_muldiv: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit, parametrised in XLEN, sitting beside the single-cycle ALU in the execute stage of the multicycle core. It accepts one operation per start pulse, latches operands, and computes with a radix-2 shift-add multiplier or a restoring divider. It returns the XLEN-bit result with a one-cycle done pulse. The control FSM stalls on busy_o and may abort an operation with kill_i.

---
 rtl/alu_muldiv.sv | 174 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit for the RV32M/RV64M extension.
// A radix-2 shift-add multiplier and a restoring divider share one 2*XLEN accumulator.
// Each operation takes one cycle to latch, XLEN CALC cycles, one FIX cycle and one DONE cycle.
// Division by zero and signed overflow skip CALC and FIX and go straight to DONE.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   request; accepted in IDLE or DONE
//   kill_i    abort while in CALC or FIX
//   funct3_i  M-extension funct3 (MUL..REMU)
//   A_i, B_i  rs1 / rs2 operands
//   busy_o    operation in flight (registered)
//   done_o    one-cycle completion pulse (registered)
//   result_o  result, held until the next done_o (registered)
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic                neg_q, neg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode at latch time
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    is_div   = funct3_i[2];
    // A signed for MULH(1), MULHSU(2), DIV(4), REM(6)
    a_sgn    = is_div ? ~funct3_i[0] : (funct3_i[0] ^ funct3_i[1]);
    // B signed for MULH(1), DIV(4), REM(6)
    b_sgn    = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
    a_neg    = a_sgn & A_i[XLEN-1];
    b_neg    = b_sgn & B_i[XLEN-1];
    a_mag    = a_neg ? (~A_i + 1'b1) : A_i;
    b_mag    = b_neg ? (~B_i + 1'b1) : B_i;
    b_zero   = (B_i == '0);
    ovf      = is_div && !funct3_i[0] && (A_i == {1'b1, {(XLEN-1){1'b0}}}) && (&B_i);
    special  = is_div && (b_zero || ovf);
    if (b_zero) spec_res = funct3_i[1] ? A_i : '1;
    else        spec_res = funct3_i[1] ? '0 : A_i;
  end

  // One iteration of each datapath
  logic [XLEN:0]     mul_sum, div_hi, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Shifted partial remainder; XLEN+1 bits so the borrow is the trial MSB.
    div_hi   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_hi - {1'b0, b_q};
    div_ok   = ~div_diff[XLEN];
    div_next = {(div_ok ? div_diff[XLEN-1:0] : div_hi[XLEN-1:0]), acc_q[XLEN-2:0], div_ok};

    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      3'd0:                fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_res = neg_q ? (~quo + 1'b1) : quo;
      default:             fix_res = neg_q ? (~rem + 1'b1) : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          op_d  = funct3_i;
          a_d   = a_mag;
          b_d   = b_mag;
          // Remainder follows the dividend; everything else follows the operand signs.
          neg_d = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d = '0;
          if (special) begin
            result_d = spec_res;
            state_d  = StDone;
          end else begin
            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (kill_i) begin
          state_d = StIdle;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) state_d = StFix;
        end
      end
      StFix: begin
        if (kill_i) begin
          state_d = StIdle;
        end else begin
          result_d = fix_res;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StCalc) || (state_d == StFix);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] result;

  logic        start64 = 1'b0, kill64 = 1'b0;
  logic [2:0]  funct3_64 = '0;
  logic [63:0] A64 = '0, B64 = '0;
  logic        busy64, done64;
  logic [63:0] result64;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .kill_i(kill), .funct3_i(funct3),
    .A_i(A), .B_i(B), .busy_o(busy), .done_o(done), .result_o(result)
  );

  alu_muldiv #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start64), .kill_i(kill64), .funct3_i(funct3_64),
    .A_i(A64), .B_i(B64), .busy_o(busy64), .done_o(done64), .result_o(result64)
  );

  always @(negedge clk) if (rst_n && ((busy && done) || (busy64 && done64))) overlap++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op (in the current cycle if now=1) and waits for done_o.
  task automatic run_op(input bit now, input bit k, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output int dcyc,
                        output int nbusy, output logic bat);
    if (!now) step();
    start = 1'b1; kill = k; funct3 = f; A = a; B = b;
    step();
    start = 1'b0; kill = 1'b0;
    res = '0; dcyc = -1; nbusy = 0; bat = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        dcyc = c; res = result; bat = busy;
        break;
      end
      if (busy) nbusy++;
      step();
    end
  endtask

  task automatic test_reset();
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
  endtask

  task automatic test_mul();
    logic [31:0] r; int d, nb; logic bat;
    run_op(1'b0, 1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, r, d, nb, bat);
    total += 4;
    if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result got=%h want=ffffffeb", r); end
    if (d !== 34) begin bad++; $display("FAIL mul_done_cycle got=%0d want=34", d); end
    if (nb !== 33) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=33", nb); end
    if (bat !== 1'b0) begin bad++; $display("FAIL mul_busy_at_done got=%b want=0", bat); end
  endtask

  task automatic test_mulh();
    logic [2:0]  fv [3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] ev [3] = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
    logic [31:0] r; int d, nb; logic bat;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 1'b0, fv[i], 32'h8000_0000, 32'h8000_0000, r, d, nb, bat);
      total++;
      if (r !== ev[i]) begin
        bad++; $display("FAIL mulh_f%0d got=%h want=%h", fv[i], r, ev[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fv [3] = '{3'd4, 3'd6, 3'd5};
    logic [31:0] ev [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
    logic [31:0] r; int d, nb; logic bat;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 1'b0, fv[i], 32'hFFFF_FFF9, 32'd2, r, d, nb, bat);
      total += 2;
      if (r !== ev[i]) begin
        bad++; $display("FAIL div_f%0d got=%h want=%h", fv[i], r, ev[i]);
      end
      if (d !== 34) begin bad++; $display("FAIL div_f%0d_cycle got=%0d want=34", fv[i], d); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fv [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r; int d, nb; logic bat;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 1'b0, fv[i], av[i], bv[i], r, d, nb, bat);
      total += 3;
      if (r !== ev[i]) begin bad++; $display("FAIL special%0d got=%h want=%h", i, r, ev[i]); end
      if (d !== 1) begin bad++; $display("FAIL special%0d_cycle got=%0d want=1", i, d); end
      if (bat !== 1'b0) begin bad++; $display("FAIL special%0d_busy got=%b want=0", i, bat); end
    end
  endtask

  task automatic test_kill();
    logic [31:0] r; int d, nb; logic bat;
    int ndone = 0, nbusy_late = 0;
    logic busy10 = 1'b0;
    run_op(1'b0, 1'b0, 3'd0, 32'd2, 32'd5, r, d, nb, bat);
    total++;
    if (r !== 32'd10) begin bad++; $display("FAIL kill_pre got=%h want=0000000a", r); end
    step();
    start = 1'b1; funct3 = 3'd0; A = 32'd3; B = 32'd4;
    step();
    for (int c = 1; c <= 60; c++) begin
      start = (c == 5);
      if (c == 5) begin A = 32'd5; B = 32'd6; end
      kill = (c == 10);
      if (c == 10) busy10 = busy;
      if (done) ndone++;
      if (c >= 11 && busy) nbusy_late++;
      step();
    end
    start = 1'b0; kill = 1'b0;
    total += 4;
    if (busy10 !== 1'b1) begin bad++; $display("FAIL kill_busy_c10 got=%b want=1", busy10); end
    if (ndone !== 0) begin bad++; $display("FAIL kill_no_done got=%0d want=0", ndone); end
    if (nbusy_late !== 0) begin bad++; $display("FAIL kill_busy_after got=%0d want=0", nbusy_late); end
    if (result !== 32'd10) begin bad++; $display("FAIL kill_result_held got=%h want=0000000a", result); end
    run_op(1'b0, 1'b0, 3'd0, 32'd3, 32'd4, r, d, nb, bat);
    total += 2;
    if (r !== 32'd12) begin bad++; $display("FAIL kill_rerun got=%h want=0000000c", r); end
    if (d !== 34) begin bad++; $display("FAIL kill_rerun_cycle got=%0d want=34", d); end
    // kill together with start in IDLE must not block the start
    run_op(1'b0, 1'b1, 3'd0, 32'd2, 32'd3, r, d, nb, bat);
    total += 2;
    if (r !== 32'd6) begin bad++; $display("FAIL kill_start_idle got=%h want=00000006", r); end
    if (d !== 34) begin bad++; $display("FAIL kill_start_idle_cycle got=%0d want=34", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int d, nb; logic bat;
    run_op(1'b0, 1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, r, d, nb, bat);
    run_op(1'b1, 1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, r, d, nb, bat);
    total += 2;
    if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL b2b_div got=%h want=fffffffd", r); end
    if (d !== 34) begin bad++; $display("FAIL b2b_div_cycle got=%0d want=34", d); end
    run_op(1'b0, 1'b0, 3'd5, 32'd5, 32'd0, r, d, nb, bat);
    run_op(1'b1, 1'b0, 3'd7, 32'd5, 32'd0, r, d, nb, bat);
    total += 2;
    if (r !== 32'd5) begin bad++; $display("FAIL b2b_remu got=%h want=00000005", r); end
    if (d !== 1) begin bad++; $display("FAIL b2b_remu_cycle got=%0d want=1", d); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    logic busy20;
    step();
    start = 1'b1; funct3 = 3'd4; A = 32'hFFFF_FFF9; B = 32'd2;
    step();
    start = 1'b0;
    repeat (19) step();
    busy20 = busy;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (busy20 !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy20); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
    if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", result); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (done) ndone++;
      step();
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", ndone); end
  endtask

  task automatic test_xlen64();
    int d = -1;
    logic [63:0] r = '0;
    step();
    start64 = 1'b1; funct3_64 = 3'd3; A64 = '1; B64 = '1;
    step();
    start64 = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (done64) begin d = c; r = result64; break; end
      step();
    end
    total += 2;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      bad++; $display("FAIL x64_mulhu got=%h want=fffffffffffffffe", r);
    end
    if (d !== 66) begin bad++; $display("FAIL x64_cycle got=%0d want=66", d); end
  endtask

  task automatic test_overlap();
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL busy_done_overlap got=%0d want=0", overlap); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_xlen64();
    test_overlap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
